// File: rtl/gelato_warp_scheduler.sv
// Round-robin warp scheduler feeding the fetch stage.
// Tracks per-warp state (IDLE/READY/ISSUED), PC and active thread mask.
// Warps are launched from the dispatcher and issued one per handshake to
// fetch. Writeback and branch resolve return them with a new PC and mask,
// or retire them. Once a warp has been offered to fetch it stays offered
// until fetch accepts it, even if a higher-priority warp becomes READY.
module gelato_warp_scheduler #(
  parameter int NUM_WARPS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int THREAD_NUM = 32,
  localparam int WARP_W    = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  launch_valid,
  output logic                  launch_ready,
  input  logic [WARP_W-1:0]     launch_warp,
  input  logic [ADDR_WIDTH-1:0] launch_pc,
  input  logic [THREAD_NUM-1:0] launch_mask,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [WARP_W-1:0]     issue_warp,
  output logic [ADDR_WIDTH-1:0] issue_pc,
  output logic [THREAD_NUM-1:0] issue_mask,
  input  logic                  update_valid,
  input  logic [WARP_W-1:0]     update_warp,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [THREAD_NUM-1:0] update_mask,
  input  logic                  update_exit,
  output logic [NUM_WARPS-1:0]  idle_mask,
  output logic                  all_idle
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READY  = 2'd1;
  localparam logic [1:0] ST_ISSUED = 2'd2;

  logic [1:0]            state_reg [NUM_WARPS];
  logic [ADDR_WIDTH-1:0] pc_reg    [NUM_WARPS];
  logic [THREAD_NUM-1:0] mask_reg  [NUM_WARPS];
  logic [WARP_W-1:0]     last_grant_reg;
  logic [WARP_W-1:0]     lock_warp_reg;
  logic                  lock_reg;

  logic [NUM_WARPS-1:0]  ready_vec;
  logic                  cand_found;
  logic [WARP_W-1:0]     cand_warp;
  logic [WARP_W-1:0]     scan_idx;
  logic [WARP_W-1:0]     grant_warp;
  logic                  launch_fire;
  logic                  issue_fire;
  logic                  update_act;

  // Per-warp status vectors derived from the state registers.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_status
      assign idle_mask[gi] = (state_reg[gi] == ST_IDLE);
      assign ready_vec[gi] = (state_reg[gi] == ST_READY);
    end
  endgenerate

  assign all_idle     = &idle_mask;
  assign launch_ready = (state_reg[launch_warp] == ST_IDLE);
  assign launch_fire  = launch_valid && launch_ready;
  // Only warps actually in flight may be retaken; anything else is stale.
  assign update_act   = update_valid && (state_reg[update_warp] == ST_ISSUED);

  // Round-robin search: first READY warp after the last grant, wrapping.
  always_comb begin
    cand_found = 1'b0;
    cand_warp  = '0;
    scan_idx   = '0;
    for (int off = 1; off <= NUM_WARPS; off++) begin
      scan_idx = last_grant_reg + WARP_W'(off);
      if (!cand_found && ready_vec[scan_idx]) begin
        cand_found = 1'b1;
        cand_warp  = scan_idx;
      end
    end
  end

  // A stalled offer keeps its warp; the locked warp is still READY so its
  // pc/mask registers cannot change underneath fetch.
  assign grant_warp  = lock_reg ? lock_warp_reg : cand_warp;
  assign issue_valid = lock_reg || cand_found;
  assign issue_fire  = issue_valid && issue_ready;
  assign issue_warp  = issue_valid ? grant_warp : '0;
  assign issue_pc    = issue_valid ? pc_reg[grant_warp] : '0;
  assign issue_mask  = issue_valid ? mask_reg[grant_warp] : '0;

  // Arbitration history and offer lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= WARP_W'(NUM_WARPS - 1);
      lock_reg       <= 1'b0;
      lock_warp_reg  <= '0;
    end else if (issue_fire) begin
      last_grant_reg <= grant_warp;
      lock_reg       <= 1'b0;
    end else if (issue_valid) begin
      lock_reg      <= 1'b1;
      lock_warp_reg <= grant_warp;
    end
  end

  // Per-warp state, PC and mask. Launch, issue and update always target
  // different warps because each needs a different current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_reg[w] <= ST_IDLE;
        pc_reg[w]    <= '0;
        mask_reg[w]  <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (launch_fire && (launch_warp == WARP_W'(w))) begin
          pc_reg[w]    <= launch_pc;
          mask_reg[w]  <= launch_mask;
          state_reg[w] <= (launch_mask != '0) ? ST_READY : ST_IDLE;
        end
        if (issue_fire && (grant_warp == WARP_W'(w))) begin
          state_reg[w] <= ST_ISSUED;
        end
        if (update_act && (update_warp == WARP_W'(w))) begin
          if (update_exit || (update_mask == '0)) begin
            state_reg[w] <= ST_IDLE;
            pc_reg[w]    <= '0;
            mask_reg[w]  <= '0;
          end else begin
            state_reg[w] <= ST_READY;
            pc_reg[w]    <= update_pc;
            mask_reg[w]  <= update_mask;
          end
        end
      end
    end
  end

endmodule
